// File: rtl/lfsr_burst_ctrl.sv
// Command-driven burst sequencer around an 8-bit Galois m-sequence LFSR
// (x^8+x^6+x^5+x^4+1). Each command optionally seeds, then streams N states.
module lfsr_burst_ctrl #(
  parameter int         LEN_W       = 16,
  parameter logic [7:0] TOGGLE_MASK = 8'h71
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_seed,
  input  logic             cmd_load,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Once out_valid is high, out_data/out_last stay stable until the word is
  // taken (or the burst is aborted); cmd_ready does not depend on cmd_valid.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [7:0]       start_q, start_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             wrap_q, wrap_d;
  logic [7:0]       lfsr_adv;
  logic [7:0]       seed_safe;
  logic             is_last;

  assign lfsr_adv  = {lfsr_q[6:0], 1'b0} ^ (lfsr_q[7] ? TOGGLE_MASK : 8'h00);
  // All-zero is the lock-up state of the register, so it is never loaded.
  assign seed_safe = (cmd_seed == 8'h00) ? 8'h01 : cmd_seed;
  assign is_last   = (cnt_q == (len_q - LEN_W'(1)));

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_load) lfsr_d = seed_safe;
          start_d = cmd_load ? seed_safe : lfsr_q;
          cnt_d   = '0;
          len_d   = cmd_len;
          state_d = (cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          lfsr_d = lfsr_adv;
          cnt_d  = cnt_q + LEN_W'(1);
          wrap_d = (lfsr_adv == start_q);
          if (is_last) state_d = DONE;
        end
        // A word handshaken together with abort is still consumed above.
        if (abort) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= 8'h01;
      start_q <= 8'h01;
      cnt_q   <= '0;
      len_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      wrap_q  <= wrap_d;
    end
  end

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == RUN);
  assign out_data  = lfsr_q;
  assign out_last  = (state_q == RUN) && is_last;
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign wrap      = wrap_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Bench for lfsr_burst_ctrl: directed vector table, hand sequences and random
// commands checked against a sequence-position model of the m-sequence.
module tb_lfsr_burst_ctrl;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_seed;
  logic             cmd_load;
  logic [LEN_W-1:0] cmd_len;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             wrap;
  logic [1:0]       dbg_state;

  lfsr_burst_ctrl #(.LEN_W(LEN_W), .TOGGLE_MASK(8'h71)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_seed(cmd_seed), .cmd_load(cmd_load), .cmd_len(cmd_len), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .wrap(wrap),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         failures = 0;
  logic [8:0] exp_q[$];          // {last, data}
  logic [7:0] seq[0:254];        // m-sequence starting at 01
  int         pos[0:255];        // index of each state in seq
  logic [7:0] model_lfsr;
  int         done_cnt = 0;
  int         wrap_cnt = 0;
  bit         mon_en = 1'b1;
  logic [6:0] pat = 7'b1101001;  // out_ready per cycle: 1,0,0,1,0,1,1

  typedef struct {
    logic [7:0] seed;
    bit         load;
    int         len;
    int         abort_at;
    int         rmode;
    logic [7:0] exp_final;
    int         exp_wraps;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Multiplication by x modulo the polynomial 0x171 walks the whole cycle.
  function automatic void build_seq();
    int s;
    s = 1;
    for (int i = 0; i < 256; i++) pos[i] = 0;
    for (int i = 0; i < 255; i++) begin
      seq[i] = s[7:0];
      pos[s] = i;
      s = s * 2;
      if (s >= 256) s = s ^ 'h171;
    end
  endfunction

  function automatic logic [7:0] mword(input logic [7:0] st, input int k);
    return seq[(pos[st] + k) % 255];
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) done_cnt++;
        if (wrap) wrap_cnt++;
        if (mon_en && out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_word actual=%0h required=none", out_data);
          end else begin
            e = exp_q[0];
            check(out_ready ? "word_data" : "held_data", {24'd0, out_data}, {24'd0, e[7:0]});
            check(out_ready ? "word_last" : "held_last", {31'd0, out_last}, {31'd0, e[8]});
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_cmd(input logic [7:0] seed, input bit load, input int len,
                         input int abort_at, input int rmode, input bit use_const,
                         input logic [7:0] c_final, input int c_wraps);
    logic [7:0] st;
    logic [7:0] exp_final;
    int n, cyc, hs, exp_wraps;
    bit fin;
    st = load ? ((seed == 8'h00) ? 8'h01 : seed) : model_lfsr;
    n  = (abort_at > 0 && abort_at < len) ? abort_at : len;
    for (int k = 0; k < n; k++) exp_q.push_back({1'(k == len - 1), mword(st, k)});
    model_lfsr = mword(st, n);
    exp_final  = use_const ? c_final : model_lfsr;
    exp_wraps  = use_const ? c_wraps : n / 255;

    @(posedge clk); #1;
    done_cnt  = 0;
    wrap_cnt  = 0;
    cmd_valid = 1'b1;
    cmd_seed  = seed;
    cmd_load  = load;
    cmd_len   = len[LEN_W-1:0];
    @(negedge clk);
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_seed  = 8'($urandom);
    cyc = 0; hs = 0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc < 7) ? pat[cyc] : 1'b1;
      endcase
      abort = (abort_at > 0) && (hs == abort_at - 1) && out_ready;
      @(negedge clk);
      if (cyc == 0) begin
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("valid_after_accept", {31'd0, out_valid}, {31'd0, 1'(len != 0)});
      end
      if (out_valid && out_ready) hs++;
      if (done) fin = 1'b1;
      cyc++;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL burst_timeout actual=no_done required=done");
    end
    out_ready = 1'b0;
    check("handshakes", hs, n);
    @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("wrap_pulses", wrap_cnt, exp_wraps);
    check("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("final_lfsr", {24'd0, out_data}, {24'd0, exp_final});
    check("exp_q_drained", exp_q.size(), 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int len, ab;
    build_seq();
    vecs[0] = '{8'h01, 1'b1,   4, 0, 0, 8'h10, 0};
    vecs[1] = '{8'h80, 1'b1,   3, 0, 0, 8'hB5, 0};
    vecs[2] = '{8'h00, 1'b0,   2, 0, 0, 8'h36, 0};
    vecs[3] = '{8'h00, 1'b1,   2, 0, 0, 8'h04, 0};
    vecs[4] = '{8'h01, 1'b1, 256, 0, 0, 8'h02, 1};
    vecs[5] = '{8'h01, 1'b1,   4, 0, 2, 8'h10, 0};
    vecs[6] = '{8'h01, 1'b1,  10, 3, 0, 8'h08, 0};
    vecs[7] = '{8'h5A, 1'b1,   0, 0, 0, 8'h5A, 0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_seed = 8'h00; cmd_load = 1'b0;
    cmd_len = '0; abort = 1'b0; out_ready = 1'b0;
    model_lfsr = 8'h01;
    #2;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wrap", {31'd0, wrap}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_lfsr", {24'd0, out_data}, 32'h01);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 8; i++)
      run_cmd(vecs[i].seed, vecs[i].load, vecs[i].len, vecs[i].abort_at,
              vecs[i].rmode, 1'b1, vecs[i].exp_final, vecs[i].exp_wraps);

    // Asynchronous reset in the middle of a burst.
    mon_en = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_seed = 8'h37; cmd_load = 1'b1; cmd_len = 16'd50;
    out_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("arst_lfsr", {24'd0, out_data}, 32'h01);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    exp_q.delete();
    model_lfsr = 8'h01;
    mon_en = 1'b1;
    @(negedge clk);
    check("arst_no_done", done_cnt, done_cnt - (done ? 1 : 0));
    run_cmd(8'hFF, 1'b0, 3, 0, 0, 1'b1, 8'h08, 0);

    // Random commands against the model.
    for (int i = 0; i < 25; i++) begin
      len = $urandom_range(0, 40);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 1) : 0;
      run_cmd(8'($urandom), 1'($urandom_range(0, 1)), len, ab,
              $urandom_range(0, 1), 1'b0, 8'h00, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
